// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: RV32I load/store data memory with valid/ready request and
// response handshakes, one outstanding request, configurable read latency.
//
// Optional feature macro: DMEM_INIT_CLEAR_EN
//   defined   - after reset release an INIT sweep zeroes one word per cycle
//               for DEPTH_WORDS cycles before the first request is accepted.
//   undefined - no INIT state; array contents are undefined until written.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I width code (B/H/W/BU/HU)
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           extended load data; 0 for stores and faults
//   rsp_fault           illegal funct3, misaligned or out-of-range access
module dmem_lsu_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 2;
    localparam bit          LAT1  = (READ_LAT <= 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT1 ? 0 : READ_LAT - 2);

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_RESP} state_t;
    localparam state_t RST_STATE = ST_INIT;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_req_ready, r_rsp_valid, r_rsp_fault;
    logic [31:0]        r_rsp_rdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept, w_fault, w_store_en, w_clr_en;
    logic [IDX_W-1:0]   w_idx, w_clr_idx;
    logic [31:0]        w_word, w_shifted, w_load, w_rsp_data, w_lane_data;
    logic [15:0]        w_half;
    logic [7:0]         w_byte;
    logic [3:0]         w_be;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

    // r_req_ready is only ever set in IDLE, so it alone qualifies acceptance
    assign w_accept = req_valid & r_req_ready;
    assign w_idx    = req_addr[IDX_W+1:2];
    assign w_word   = r_mem[w_idx];

    // Fault classification: illegal code, store of BU/HU, misalignment, range
    always_comb begin
        w_fault = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            w_fault = 1'b1;
        if (req_write && req_funct3[2])
            w_fault = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            w_fault = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            w_fault = 1'b1;
        if (|req_addr[ADDR_W-1:IDX_W+2])
            w_fault = 1'b1;
    end

    // Load lane select and extension; funct3[2] selects zero-extension
    always_comb begin
        w_shifted = w_word >> {req_addr[1:0], 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = req_addr[1] ? w_word[31:16] : w_word[15:0];
        case (req_funct3[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~req_funct3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~req_funct3[2]}}, w_half};
            default: w_load = w_word;
        endcase
        w_rsp_data = (req_write || w_fault) ? 32'h0 : w_load;
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = req_wdata;
            end
        endcase
    end

    assign w_store_en = w_accept & req_write & ~w_fault;

`ifdef DMEM_INIT_CLEAR_EN
    logic [IDX_W-1:0] r_clr_idx;

    // Sweep pointer restarts from word 0 on every reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_clr_idx <= '0;
        else if (r_state == ST_INIT)
            r_clr_idx <= r_clr_idx + IDX_W'(1);
    end

    assign w_clr_en  = (r_state == ST_INIT);
    assign w_clr_idx = r_clr_idx;
`else
    assign w_clr_en  = 1'b0;
    assign w_clr_idx = '0;
`endif

    // Word array: not reset; written by the clear sweep or committed stores
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_store_en) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
`ifdef DMEM_INIT_CLEAR_EN
            ST_INIT: if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) w_state_nxt = ST_IDLE;
`endif
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_write || w_fault || LAT1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) w_state_nxt = ST_RESP;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RST_STATE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_fault <= w_fault;
            end
        end
    end

endmodule
